// File: rtl/coin_frame_scheduler.sv
// Coin/buy scheduler for the vending machine serial port: round-robin coin frames,
// LSB-first serialization with a one-cycle enable drop, buys interleaved between frames.
module coin_frame_scheduler #(
  parameter int                  FRAME_LEN    = 12,
  parameter int                  GAP          = 3,
  parameter logic [FRAME_LEN-1:0] PENNY_CODE   = 12'b101111000000,
  parameter logic [FRAME_LEN-1:0] NICKEL_CODE  = 12'b110100000000,
  parameter logic [FRAME_LEN-1:0] DIME_CODE    = 12'b101100000000,
  parameter logic [FRAME_LEN-1:0] QUARTER_CODE = 12'b111011110000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] coin_req,
  output logic [3:0] coin_ack,
  input  logic       buy_req,
  input  logic [1:0] buy_product,
  output logic       buy_ack,
  output logic       serial_out,
  output logic       enable,
  output logic       buy,
  output logic [1:0] product,
  output logic       busy
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_S, BUY} state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [1:0]           rr;
  logic                 last_was_coin;

  logic                 decide;
  logic                 take_buy;
  logic                 take_coin;
  logic [1:0]           grant;

  // Circular search starting at ptr+1; ptr itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [FRAME_LEN-1:0] code_of(input logic [1:0] k);
    case (k)
      2'd0:    code_of = PENNY_CODE;
      2'd1:    code_of = NICKEL_CODE;
      2'd2:    code_of = DIME_CODE;
      default: code_of = QUARTER_CODE;
    endcase
  endfunction

  // The last gap cycle makes the same decision as IDLE, so back-to-back frames
  // start every FRAME_LEN+GAP cycles without an extra idle cycle.
  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    decide    = (state == IDLE) || (state == GAP_S && gap_cnt == GW'(GAP - 1));
    take_buy  = buy_req && ((coin_req == 4'b0000) || last_was_coin);
    take_coin = !take_buy && (coin_req != 4'b0000);
    grant     = rr_pick(coin_req, rr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the shift register is reset too; an aborted frame must never leak stale bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      rr            <= 2'd3;
      last_was_coin <= 1'b0;
      coin_ack      <= 4'b0000;
      buy_ack       <= 1'b0;
      serial_out    <= 1'b0;
      enable        <= 1'b1;
      buy           <= 1'b0;
      product       <= 2'd0;
      busy          <= 1'b0;
    end else begin
      coin_ack <= 4'b0000;
      buy_ack  <= 1'b0;
      buy      <= 1'b0;
      enable   <= 1'b1;

      if (decide) begin
        if (take_buy) begin
          state         <= BUY;
          buy           <= 1'b1;
          buy_ack       <= 1'b1;
          product       <= buy_product;
          last_was_coin <= 1'b0;
          serial_out    <= 1'b0;
          busy          <= 1'b1;
        end else if (take_coin) begin
          state           <= SHIFT;
          shreg           <= code_of(grant);
          serial_out      <= code_of(grant)[0];
          enable          <= 1'b0;
          coin_ack[grant] <= 1'b1;
          rr              <= grant;
          last_was_coin   <= 1'b1;
          bit_cnt         <= '0;
          busy            <= 1'b1;
        end else begin
          state      <= IDLE;
          serial_out <= 1'b0;
          busy       <= 1'b0;
        end
      end else begin
        case (state)
          SHIFT: begin
            if (bit_cnt == CW'(FRAME_LEN - 1)) begin
              state      <= GAP_S;
              gap_cnt    <= '0;
              serial_out <= 1'b0;
            end else begin
              shreg      <= shreg >> 1;
              serial_out <= shreg[1];
              bit_cnt    <= bit_cnt + CW'(1);
            end
          end
          BUY: begin
            state      <= GAP_S;
            gap_cnt    <= '0;
            serial_out <= 1'b0;
          end
          GAP_S: begin
            gap_cnt    <= gap_cnt + GW'(1);
            serial_out <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coin_frame_scheduler.sv
// Directed bench for coin_frame_scheduler: frame bit patterns, round-robin order,
// coin/buy alternation, mid-frame reset and pointer-dependent grant order.
module tb_coin_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] coin_req;
  logic [3:0] coin_ack;
  logic       buy_req;
  logic [1:0] buy_product;
  logic       buy_ack;
  logic       serial_out;
  logic       enable;
  logic       buy;
  logic [1:0] product;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  coin_frame_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .coin_req   (coin_req),
    .coin_ack   (coin_ack),
    .buy_req    (buy_req),
    .buy_product(buy_product),
    .buy_ack    (buy_ack),
    .serial_out (serial_out),
    .enable     (enable),
    .buy        (buy),
    .product    (product),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    coin_req    = 4'b0000;
    buy_req     = 1'b0;
    buy_product = 2'd0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Caller has just sampled bit 0; checks all bits and the enable pattern.
  task automatic check_frame(input string tag, input logic [11:0] seq);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      check({tag, "_bit"}, serial_out, seq[i]);
      check({tag, "_en"}, enable, (i == 0) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic check_gap(input string tag);
    for (int g = 0; g < 3; g++) begin
      tick();
      check({tag, "_gap_ser"}, serial_out, 1'b0);
      check({tag, "_gap_en"}, enable, 1'b1);
      check({tag, "_gap_busy"}, busy, 1'b1);
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // Hand-computed LSB-first bit sequences (element i = bit driven in frame cycle i).
  logic [11:0] penny_seq;
  logic [11:0] quarter_seq;
  logic [11:0] dime_seq;
  logic [3:0]  rr_order [5];

  initial begin
    penny_seq   = 12'b1011_1100_0000;  // 0,0,0,0,0,0,1,1,1,1,0,1
    quarter_seq = 12'b1110_1111_0000;  // 0,0,0,0,1,1,1,1,0,1,1,1
    dime_seq    = 12'b1011_0000_0000;  // 0,0,0,0,0,0,0,0,1,1,0,1
    rr_order[0] = 4'b0001;
    rr_order[1] = 4'b0010;
    rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000;
    rr_order[4] = 4'b0001;

    // Reset values
    do_reset();
    check("rst_ser", serial_out, 1'b0);
    check("rst_en", enable, 1'b1);
    check("rst_buy", buy, 1'b0);
    check("rst_prod", product, 2'd0);
    check("rst_ack", coin_ack, 4'b0000);
    check("rst_bak", buy_ack, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Single penny frame
    coin_req = 4'b0001;
    tick();
    check("penny_ack", coin_ack, 4'b0001);
    check("penny_busy", busy, 1'b1);
    coin_req = 4'b0000;
    check_frame("penny", penny_seq);
    tick();
    check("penny_ack_off", coin_ack, 4'b0000);
    check("penny_g0_ser", serial_out, 1'b0);
    tick();
    tick();
    check("penny_g2_busy", busy, 1'b1);
    tick();
    check("penny_done", busy, 1'b0);

    // Round robin, all four requesting continuously
    do_reset();
    coin_req = 4'b1111;
    for (int c = 0; c < 75; c++) begin
      tick();
      check("rr_ack", coin_ack, (c % 15 == 0) ? rr_order[c / 15] : 4'b0000);
      check("rr_en", enable, (c % 15 == 0) ? 1'b0 : 1'b1);
      if (c % 15 == 0) coin_req = coin_req & ~rr_order[c / 15];
      if (c % 15 == 1) coin_req = coin_req | rr_order[c / 15];
    end
    coin_req = 4'b0000;
    wait_idle("rr", 40);

    // Quarter and buy together: coin first, then buy
    do_reset();
    coin_req    = 4'b1000;
    buy_req     = 1'b1;
    buy_product = 2'd2;
    tick();
    check("qb_ack", coin_ack, 4'b1000);
    check("qb_nobuy", buy, 1'b0);
    coin_req = 4'b0000;
    check_frame("quarter", quarter_seq);
    check_gap("quarter");
    tick();
    check("qb_buy", buy, 1'b1);
    check("qb_bak", buy_ack, 1'b1);
    check("qb_prod", product, 2'd2);
    check("qb_en", enable, 1'b1);
    buy_req = 1'b0;
    tick();
    check("qb_buy_off", buy, 1'b0);
    check("qb_bak_off", buy_ack, 1'b0);
    wait_idle("qb", 10);
    check("qb_prod_hold", product, 2'd2);

    // Buy alone
    buy_req     = 1'b1;
    buy_product = 2'd3;
    tick();
    check("b_buy", buy, 1'b1);
    check("b_bak", buy_ack, 1'b1);
    check("b_prod", product, 2'd3);
    check("b_ser", serial_out, 1'b0);
    check("b_en", enable, 1'b1);
    buy_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("b_after_buy", buy, 1'b0);
      check("b_after_ser", serial_out, 1'b0);
      check("b_after_en", enable, 1'b1);
    end
    check("b_done", busy, 1'b0);
    check("b_prod_hold", product, 2'd3);

    // Reset in the middle of a dime frame
    do_reset();
    coin_req = 4'b0100;
    tick();
    check("dime_ack", coin_ack, 4'b0100);
    for (int i = 1; i <= 5; i++) tick();
    check("dime_b5_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("dime_rst_en", enable, 1'b1);
    check("dime_rst_ser", serial_out, 1'b0);
    check("dime_rst_busy", busy, 1'b0);
    check("dime_rst_ack", coin_ack, 4'b0000);
    tick();
    reset = 1'b1;
    tick();
    check("dime_re_ack", coin_ack, 4'b0100);
    coin_req = 4'b0000;
    check_frame("dime", dime_seq);
    check_gap("dime");
    tick();
    check("dime_done", busy, 1'b0);

    // Pointer at 1: requester 2 wins over 1, then 1
    do_reset();
    coin_req = 4'b0010;
    tick();
    check("p_first", coin_ack, 4'b0010);
    coin_req = 4'b0000;
    wait_idle("p_first", 20);
    coin_req = 4'b0110;
    tick();
    check("p_two", coin_ack, 4'b0100);
    coin_req = 4'b0010;
    for (int c = 0; c < 15; c++) tick();
    check("p_one", coin_ack, 4'b0010);
    check("p_one_en", enable, 1'b0);
    coin_req = 4'b0000;
    wait_idle("p_end", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/coin_frame_scheduler.md
Name: coin_frame_scheduler

Overview:
- Controller that drives the vending machine's serial coin port (serialIn/enable) and its buy/product inputs from several independent coin acceptors and one purchase keypad.
- Round-robin arbitration picks one pending coin per frame. The chosen 12-bit coin code is serialized LSB first, with the one-cycle enable drop that tells the machine to latch the frame.
- Buy commands are interleaved between frames so a purchase never corrupts an in-flight coin frame.

Parameters:
- FRAME_LEN, 12, bits per coin frame.
- GAP, 3, idle cycles inserted after every frame or buy pulse (min 1).
- PENNY_CODE, 12'b101111000000, frame for requester 0.
- NICKEL_CODE, 12'b110100000000, frame for requester 1.
- DIME_CODE, 12'b101100000000, frame for requester 2.
- QUARTER_CODE, 12'b111011110000, frame for requester 3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_req  in  4  per-acceptor request level; held until matching coin_ack.
- coin_ack  out  4  one-hot, one-cycle pulse in the cycle bit 0 of that requester's frame is driven.
- buy_req  in  1  purchase request level; held until buy_ack.
- buy_product  in  2  product select; sampled when the buy is issued.
- buy_ack  out  1  one-cycle pulse coincident with buy.
- serial_out  out  1  to vendingMachine serialIn.
- enable  out  1  to vendingMachine enable; low exactly one cycle per frame.
- buy  out  1  to vendingMachine buy.
- product  out  2  to vendingMachine product; holds last issued value.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-frame) sets:
  - state IDLE; serial_out=0, enable=1, buy=0, product=0, coin_ack=0, buy_ack=0, busy=0.
  - rr pointer=3, so requester 0 has first priority; last_was_coin=0.
  - bit and gap counters cleared.
  - An aborted frame is not resumed; its requester is still un-acked and re-arbitrates normally.
- States: IDLE, SHIFT, GAP, BUY.
- IDLE, decision at each clock edge:
  - Buy wins when buy_req=1 and (coin_req==0 or last_was_coin=1) -> BUY.
  - Otherwise, if coin_req!=0 -> SHIFT.
  - Otherwise stay in IDLE.
- Entering SHIFT, same edge:
  - Grant k = first set bit of coin_req, searching circularly from rr+1.
  - Load shift reg with code k; serial_out=code[0]; enable=0; coin_ack[k]=1; rr=k; last_was_coin=1.
- SHIFT:
  - On each of the next FRAME_LEN-1 edges, serial_out = next higher bit; enable=1; coin_ack=0.
  - After bit FRAME_LEN-1 has been driven for one cycle -> GAP.
  - A frame therefore occupies exactly FRAME_LEN cycles; request-to-bit0 latency is one edge.
- BUY, one cycle:
  - buy=1, buy_ack=1, product=buy_product as sampled on the entry edge; last_was_coin=0.
  - Next edge -> GAP with buy=0.
- GAP:
  - serial_out=0, enable=1, buy=0 for GAP cycles, then IDLE.
  - Gives requesters time to drop req after their ack.
- Fairness:
  - Coins rotate round-robin, so no acceptor waits more than 3 frames.
  - A pending buy is served no later than after the next coin frame (alternation via last_was_coin).
- Simultaneous events:
  - A coin_req asserting during SHIFT/GAP/BUY is queued by level and considered at the next IDLE.
  - A req de-asserted before grant is never served.
  - coin_req changing mid-frame does not affect the frame in flight.
- product is never changed except on entry to BUY.
- Requirements on requesters:
  - coin_req[k] is held until coin_ack[k]; a request dropped before grant is simply not served.
  - coin_req[k] must drop within GAP+FRAME_LEN cycles after coin_ack[k], otherwise it is a new request.
  - buy_req and buy_product must not change while a request is pending, until buy_ack.

Test Plan:
- Reset release, coin_req=4'b0001 -> next edge coin_ack=0001 and enable=0; serial_out sequence over 12 cycles = 0,0,0,0,0,0,1,1,1,1,0,1 (PENNY LSB first); then 3 GAP cycles, busy=0.
- coin_req=4'b1111 held continuously (each dropped one cycle after its ack, then re-raised) -> grant order 0,1,2,3,0; frames start every 15 cycles; enable low exactly at each frame start.
- coin_req=4'b1000 and buy_req=1, buy_product=2, both asserted together -> QUARTER frame first (bits 0,0,0,0,1,1,1,1,0,1,1,1), GAP, then buy=1/buy_ack=1 for one cycle with product=2; product stays 2 afterwards.
- buy_req alone, buy_product=3 -> buy pulse one edge after request; serial_out=0 and enable=1 throughout.
- reset asserted low at bit 5 of a DIME frame -> outputs return to reset values immediately (enable=1, serial_out=0); after release with coin_req[2] still high, a full DIME frame restarts from bit 0 with coin_ack=0100.
- coin_req=4'b0110 with rr=1 -> requester 2 granted before 1; next grant goes to 1.
